bf_program_loader: RTL
======================

# bf_program_loader

Writer side of the program-memory port of the BF machine: accepts a byte stream of ASCII BF source over a valid/ready handshake, decodes the eight command characters to 4-bit opcodes, and writes them sequentially into program memory from address 0. Non-command characters are consumed and dropped. On end of stream it appends a HALT opcode, checks bracket balance, and raises `PMInputDone` so the control unit can start execution.

## Interface
- `PMAW`, 8, program-memory address width; capacity 2^PMAW words including the HALT slot.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- `inData`  in  8  ASCII source byte.
- `inValid`  in  1  `inData`/`inLast` valid.
- `inLast`  in  1  marks final byte of the stream.
- `inReady`  out  1  loader can accept a byte.
- `pmAddress`  out  PMAW  program-memory write address.
- `pmData`  out  4  opcode to write.
- `pmWren`  out  1  write strobe, one cycle per word.
- `PMInputDone`  out  1  load completed successfully; level, sticky.
- `progLen`  out  PMAW  opcodes written, excluding HALT.
- `errCode`  out  2  0 none, 1 overflow, 2 unmatched `]`, 3 unclosed `[`.
- `busy`  out  1  high in LOAD and TERM.

## Operation
- Opcodes: HALT 0, `>` 1, `<` 2, `+` 3, `-` 4, `.` 5, `,` 6, `[` 7, `]` 8; codes 9–15 unused.
- States: IDLE → (start) LOAD → (accepted `inLast`, no error) TERM → DONE. Any error in LOAD → ERR. `start` in DONE/ERR → LOAD with writePtr, depth, progLen, errCode, PMInputDone cleared. `start` in LOAD/TERM ignored.
- `inReady` = 1 only in LOAD. A byte is accepted when `inValid & inReady`.
- Accepted command byte: registered write `pmAddress <= writePtr`, `pmData <= opcode`, `pmWren <= 1`; writePtr and progLen increment. Non-command byte: no write, no pointer change.
- Bracket depth counter, PMAW+1 bits: `[` increments, `]` decrements.
- Error checks on each accepted command byte, priority: unmatched `]` (depth 0) > overflow (writePtr = 2^PMAW−1, last slot reserved for HALT). Offending byte is not written.
- On accepted `inLast`: if depth after that byte ≠ 0 → ERR, code 3, no HALT written. Otherwise TERM writes HALT at writePtr (progLen unchanged), then DONE.
- `inLast` on a non-command byte still terminates the load.
- ERR and DONE hold all outputs until `start` or reset; `inReady` = 0.

## Timing
- Reset values: state IDLE, `inReady` 0, `pmAddress` 0, `pmData` 0, `pmWren` 0, `PMInputDone` 0, `progLen` 0, `errCode` 0, `busy` 0.
- Write latency: 1 cycle from accept to `pmWren` high; sustained 1 byte/cycle.
- Last byte accepted at cycle N: its write at N+1 (if command), HALT write at N+2, `PMInputDone` high from N+2.
- Error detected on byte accepted at N: `errCode` valid and `inReady` low from N+1.
- `pmWren` never high for more than one cycle per word; never high in IDLE/DONE/ERR except the final TERM-issued write cycle.
- Reset mid-load: immediate return to IDLE; memory contents undefined beyond last completed write.

## Configuration
- `BF_LOADER_BRACKET_CHECK_EN` defined: depth counter and error codes 2/3 active as above.
- Undefined: no depth counter; `]` at depth 0 and unclosed `[` are written/accepted without error; only overflow (code 1) can occur.

## Structure
- Shared package `bf_pkg`: opcode constants, ASCII character constants, error-code constants, loader state encoding.
- Sub-module `bf_ascii_decode`: combinational, `inData` → {isCmd, opcode[3:0]}; reusable by a future disassembler/monitor.

## Test plan
- Stream "+[->+<]." with `inLast` on `.`, inValid constant → writes 3,7,4,1,3,2,8,5 at 0–7, HALT at 8, progLen 8, PMInputDone 1, errCode 0.
- "a+ b\n-" with gaps in inValid → only 3,4 written at 0,1; HALT at 2; progLen 2.
- "+]" → `+` at 0, `]` not written, errCode 2, inReady 0, no HALT; with macro off → 3,8,0 written, PMInputDone 1.
- "[[+]" ending → errCode 3, no HALT write, PMInputDone 0.
- PMAW=4, 16 `+` bytes → 15 written (0–14), 16th raises errCode 1; then `start` + "." → `.` at 0, HALT at 1, errCode 0.
- Assert reset (low) mid-stream after 3 writes → all outputs zero next edge; `start` reloads from address 0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared BF machine definitions: opcodes, source characters,
// loader error codes and loader state encoding.
package bf_pkg;

   localparam logic [3:0] OP_HALT  = 4'd0;
   localparam logic [3:0] OP_RIGHT = 4'd1;
   localparam logic [3:0] OP_LEFT  = 4'd2;
   localparam logic [3:0] OP_INC   = 4'd3;
   localparam logic [3:0] OP_DEC   = 4'd4;
   localparam logic [3:0] OP_OUT   = 4'd5;
   localparam logic [3:0] OP_IN    = 4'd6;
   localparam logic [3:0] OP_OPEN  = 4'd7;
   localparam logic [3:0] OP_CLOSE = 4'd8;

   localparam logic [7:0] CH_RIGHT = 8'h3E;
   localparam logic [7:0] CH_LEFT  = 8'h3C;
   localparam logic [7:0] CH_INC   = 8'h2B;
   localparam logic [7:0] CH_DEC   = 8'h2D;
   localparam logic [7:0] CH_OUT   = 8'h2E;
   localparam logic [7:0] CH_IN    = 8'h2C;
   localparam logic [7:0] CH_OPEN  = 8'h5B;
   localparam logic [7:0] CH_CLOSE = 8'h5D;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
   localparam logic [1:0] ERR_UNMATCHED = 2'd2;
   localparam logic [1:0] ERR_UNCLOSED  = 2'd3;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_LOAD,
      LD_TERM,
      LD_DONE,
      LD_ERR
   } loaderState_t;

endpackage

// File: rtl/bf_program_loader_if.sv
// Source byte stream into the program loader.
// master drives bytes, slave (the loader) drives inReady.
interface bf_program_loader_if;

   logic [7:0] inData;
   logic       inValid;
   logic       inLast;
   logic       inReady;

   modport master (
      output inData,
      output inValid,
      output inLast,
      input  inReady
   );

   modport slave (
      input  inData,
      input  inValid,
      input  inLast,
      output inReady
   );

endinterface

// File: rtl/bf_ascii_decode.sv
// ASCII BF command character to opcode; isCmd low for
// any other byte.
module bf_ascii_decode
   import bf_pkg::*;
(
   input  logic [7:0] inData,
   output logic       isCmd,
   output logic [3:0] opcode
);

   always_comb begin
      isCmd  = 1'b1;
      opcode = OP_HALT;
      unique case (1'b1)
         (inData == CH_RIGHT): opcode = OP_RIGHT;
         (inData == CH_LEFT):  opcode = OP_LEFT;
         (inData == CH_INC):   opcode = OP_INC;
         (inData == CH_DEC):   opcode = OP_DEC;
         (inData == CH_OUT):   opcode = OP_OUT;
         (inData == CH_IN):    opcode = OP_IN;
         (inData == CH_OPEN):  opcode = OP_OPEN;
         (inData == CH_CLOSE): opcode = OP_CLOSE;
         default:              isCmd  = 1'b0;
      endcase
   end

endmodule

// File: rtl/bf_program_loader.sv
// Loads ASCII BF source into program memory and appends HALT.
// Define BF_LOADER_BRACKET_CHECK_EN to enable bracket balance checks.
module bf_program_loader
   import bf_pkg::*;
#(
   parameter int PMAW = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   bf_program_loader_if.slave src,
   output logic [PMAW-1:0] pmAddress,
   output logic [3:0]      pmData,
   output logic            pmWren,
   output logic            PMInputDone,
   output logic [PMAW-1:0] progLen,
   output logic [1:0]      errCode,
   output logic            busy
);

   loaderState_t    state;
   logic [PMAW-1:0] writePtr;
   logic            isCmd;
   logic [3:0]      opcode;
   logic            accept;
   logic            full;
   logic            unmatched;
   logic            unclosed;

   bf_ascii_decode uDecode (
      .inData (src.inData),
      .isCmd  (isCmd),
      .opcode (opcode)
   );

   assign src.inReady = (state == LD_LOAD);
   assign busy        = (state == LD_LOAD) || (state == LD_TERM);
   assign accept      = src.inValid & src.inReady;
   assign full        = &writePtr;
   // HALT is never counted, so the length is the write pointer
   assign progLen     = writePtr;

`ifdef BF_LOADER_BRACKET_CHECK_EN
   logic [PMAW:0] depth;
   logic [PMAW:0] depthNext;

   always_comb begin
      depthNext = depth;
      if (isCmd && opcode == OP_OPEN)
         depthNext = depth + 1'b1;
      else if (isCmd && opcode == OP_CLOSE)
         depthNext = depth - 1'b1;
   end

   assign unmatched = isCmd && (opcode == OP_CLOSE) && (depth == '0);
   assign unclosed  = (depthNext != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         depth <= '0;
      else if (start && !busy)
         depth <= '0;
      else if (accept && isCmd && !unmatched && !full)
         depth <= depthNext;
   end
`else
   assign unmatched = 1'b0;
   assign unclosed  = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= LD_IDLE;
         writePtr    <= '0;
         pmAddress   <= '0;
         pmData      <= OP_HALT;
         pmWren      <= 1'b0;
         PMInputDone <= 1'b0;
         errCode     <= ERR_NONE;
      end else begin
         pmWren <= 1'b0;
         unique case (state)
            LD_IDLE, LD_DONE, LD_ERR: begin
               if (start) begin
                  state       <= LD_LOAD;
                  writePtr    <= '0;
                  PMInputDone <= 1'b0;
                  errCode     <= ERR_NONE;
               end
            end
            LD_LOAD: begin
               if (accept) begin
                  if (unmatched) begin
                     state   <= LD_ERR;
                     errCode <= ERR_UNMATCHED;
                  end else if (isCmd && full) begin
                     state   <= LD_ERR;
                     errCode <= ERR_OVERFLOW;
                  end else begin
                     if (isCmd) begin
                        pmAddress <= writePtr;
                        pmData    <= opcode;
                        pmWren    <= 1'b1;
                        writePtr  <= writePtr + 1'b1;
                     end
                     if (src.inLast) begin
                        if (unclosed) begin
                           state   <= LD_ERR;
                           errCode <= ERR_UNCLOSED;
                        end else begin
                           state <= LD_TERM;
                        end
                     end
                  end
               end
            end
            LD_TERM: begin
               pmAddress   <= writePtr;
               pmData      <= OP_HALT;
               pmWren      <= 1'b1;
               PMInputDone <= 1'b1;
               state       <= LD_DONE;
            end
            default: state <= LD_IDLE;
         endcase
      end
   end

endmodule
